// File: rtl/serdes_pkg.sv
// Shared SERDES types and helpers, used by the serializer and the future deserializer.
package serdes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } ser_state_t;

    // Clocks from the first start-bit clock to the last stop-bit clock.
    function automatic int frame_clocks(input int logic_size, input int parity_en,
                                        input int stop_bits, input int bit_cycles);
        return (1 + logic_size + parity_en + stop_bits) * bit_cycles;
    endfunction

endpackage

// File: rtl/fifo_serializer_if.sv
// FIFO read-side handshake between the async FIFO (slave) and its consumer (master).
interface fifo_serializer_if #(
    parameter int LOGIC_SIZE = 8
);
    logic                  rempty;
    logic [LOGIC_SIZE-1:0] rdata;
    logic                  rr;

    modport master (output rr, input rempty, input rdata);
    modport slave  (input rr, output rempty, output rdata);
endinterface

// File: rtl/bit_timer.sv
// Bit-period down-counter; o_tick marks the last clock of every BIT_CYCLES-long period.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);
    localparam int            CW     = $clog2(BIT_CYCLES) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (i_restart || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == '0);
endmodule

// File: rtl/fifo_serializer.sv
// TX half of the SERDES link: pops FIFO words and sends them as framed serial bits.
//   state  | meaning
//   IDLE   | line high, waiting for enable and a non-empty FIFO
//   POP    | read request to the FIFO for one clock
//   LOAD   | capture FIFO data into the shift register, arm the bit timer
//   START  | start bit (0)
//   DATA   | data bits, LSB first
//   PARITY | parity bit
//   STOP   | stop bit(s) (1)
module fifo_serializer
    import serdes_pkg::*;
#(
    parameter int LOGIC_SIZE = 8,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    fifo_serializer_if.master fifo,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_frame_done
);
    localparam int            BW        = $clog2(LOGIC_SIZE + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(LOGIC_SIZE - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          PAR_INIT  = (PARITY_ODD != 0);

    ser_state_t            state_q, state_d;
    logic [LOGIC_SIZE-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  par_q, par_d;
    logic                  tick;
    logic                  restart;

    assign restart = (state_q == LOAD);

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_restart(restart),
        .o_tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        case (state_q)
            IDLE: begin
                if (i_enable && !fifo.rempty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d   = fifo.rdata;
                par_d     = PAR_INIT;
                bit_cnt_d = '0;
                state_d   = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    par_d   = par_q ^ shreg_q[0];
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Bit counter is reused to count stop bits.
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
        end
    end

    always_comb begin
        o_tx = 1'b1;
        case (state_q)
            START:   o_tx = 1'b0;
            DATA:    o_tx = shreg_q[0];
            PARITY:  o_tx = par_q;
            default: o_tx = 1'b1;
        endcase
    end

    assign fifo.rr      = (state_q == POP);
    assign o_busy       = (state_q != IDLE);
    assign o_frame_done = (state_q == STOP) && tick && (bit_cnt_q == LAST_STOP);
endmodule
